// File: rtl/decode_stage_if.sv
// ID-stage bus: IF/ID instruction, WB write port, debug read port and ID/EX outputs.
interface decode_stage_if #(
    parameter int NB_DATA   = 32,
    parameter int NB_REG    = 5,
    parameter int NB_OPCODE = 6
);
    logic                 enable_i;
    logic                 flush_i;
    logic [NB_DATA-1:0]   instruction_i;
    logic                 reg_write_i;
    logic [NB_REG-1:0]    write_register_i;
    logic [NB_DATA-1:0]   data_rw_i;
    logic [NB_REG-1:0]    dbg_addr_i;
    logic [NB_DATA-1:0]   dbg_data_o;
    logic                 stall_o;
    logic                 halted_o;
    logic [NB_OPCODE-1:0] ex_opcode_o;
    logic [NB_OPCODE-1:0] ex_funct_o;
    logic [NB_REG-1:0]    ex_rs_o;
    logic [NB_REG-1:0]    ex_rt_o;
    logic [NB_REG-1:0]    ex_rd_o;
    logic [NB_REG-1:0]    ex_shamt_o;
    logic [NB_DATA-1:0]   ex_data_ra_o;
    logic [NB_DATA-1:0]   ex_data_rb_o;
    logic [NB_DATA-1:0]   ex_imm_o;
    logic [1:0]           ex_reg_dst_o;
    logic                 ex_alu_src_o;
    logic                 ex_mem_read_o;
    logic                 ex_mem_write_o;
    logic                 ex_mem_to_reg_o;
    logic                 ex_reg_write_o;
    logic                 ex_branch_o;

    modport master (
        output enable_i, flush_i, instruction_i, reg_write_i, write_register_i, data_rw_i, dbg_addr_i,
        input  dbg_data_o, stall_o, halted_o, ex_opcode_o, ex_funct_o, ex_rs_o, ex_rt_o, ex_rd_o,
               ex_shamt_o, ex_data_ra_o, ex_data_rb_o, ex_imm_o, ex_reg_dst_o, ex_alu_src_o,
               ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o, ex_reg_write_o, ex_branch_o
    );

    modport slave (
        input  enable_i, flush_i, instruction_i, reg_write_i, write_register_i, data_rw_i, dbg_addr_i,
        output dbg_data_o, stall_o, halted_o, ex_opcode_o, ex_funct_o, ex_rs_o, ex_rt_o, ex_rd_o,
               ex_shamt_o, ex_data_ra_o, ex_data_rb_o, ex_imm_o, ex_reg_dst_o, ex_alu_src_o,
               ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o, ex_reg_write_o, ex_branch_o
    );
endinterface

// File: rtl/decode_stage.sv
// MIPS decode stage: register bank, opcode decode, load-use stall and ID/EX register.
// Optional `REGFILE_BYPASS_EN: WB write data forwarded to same-cycle rs/rt/dbg reads.
module decode_stage #(
    parameter int NB_DATA   = 32,
    parameter int NB_REG    = 5,
    parameter int NB_OPCODE = 6
) (
    input logic           clock_i,
    input logic           reset_i,
    decode_stage_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef struct packed {
        logic [NB_OPCODE-1:0] opcode;
        logic [NB_OPCODE-1:0] funct;
        logic [NB_REG-1:0]    rs;
        logic [NB_REG-1:0]    rt;
        logic [NB_REG-1:0]    rd;
        logic [NB_REG-1:0]    shamt;
        logic [NB_DATA-1:0]   data_ra;
        logic [NB_DATA-1:0]   data_rb;
        logic [NB_DATA-1:0]   imm;
        logic [1:0]           reg_dst;
        logic                 alu_src;
        logic                 mem_read;
        logic                 mem_write;
        logic                 mem_to_reg;
        logic                 reg_write;
        logic                 branch;
    } idex_t;

    logic [NB_DATA-1:0] regs_q [2**NB_REG];
    logic [NB_DATA-1:0] regs_d [2**NB_REG];
    idex_t              ex_q, ex_d, dec;
    logic               halted_q, halted_d;

    logic [5:0]         op_raw;
    logic signed [15:0] imm16;
    logic [NB_REG-1:0]  rs, rt;
    logic               wr_hit, is_halt, stall;
    logic [NB_DATA-1:0] ra, rb, dbg;

    assign op_raw = bus.instruction_i[31:26];
    assign imm16  = $signed(bus.instruction_i[15:0]);
    assign rs     = NB_REG'(bus.instruction_i[25:21]);
    assign rt     = NB_REG'(bus.instruction_i[20:16]);
    assign wr_hit = bus.reg_write_i && (bus.write_register_i != '0);

    always_comb begin
        ra  = (rs == '0) ? '0 : regs_q[rs];
        rb  = (rt == '0) ? '0 : regs_q[rt];
        dbg = (bus.dbg_addr_i == '0) ? '0 : regs_q[bus.dbg_addr_i];
`ifdef REGFILE_BYPASS_EN
        if (wr_hit && bus.write_register_i == rs)         ra  = bus.data_rw_i;
        if (wr_hit && bus.write_register_i == rt)         rb  = bus.data_rw_i;
        if (wr_hit && bus.write_register_i == bus.dbg_addr_i) dbg = bus.data_rw_i;
`endif
    end

    // Register 0 is never written, so it stays at its reset value of 0.
    always_comb begin
        regs_d = regs_q;
        if (wr_hit) regs_d[bus.write_register_i] = bus.data_rw_i;
    end

    always_comb begin
        dec         = '0;
        dec.opcode  = NB_OPCODE'(op_raw);
        dec.funct   = NB_OPCODE'(bus.instruction_i[5:0]);
        dec.rs      = rs;
        dec.rt      = rt;
        dec.rd      = NB_REG'(bus.instruction_i[15:11]);
        dec.shamt   = NB_REG'(bus.instruction_i[10:6]);
        dec.data_ra = ra;
        dec.data_rb = rb;
        dec.imm     = NB_DATA'(imm16);
        is_halt     = 1'b0;
        case (op_raw)
            OP_RTYPE: begin dec.reg_dst = 2'b01; dec.reg_write = 1'b1; end
            OP_LW: begin
                dec.alu_src = 1'b1; dec.mem_read = 1'b1;
                dec.mem_to_reg = 1'b1; dec.reg_write = 1'b1;
            end
            OP_SW:   begin dec.alu_src = 1'b1; dec.mem_write = 1'b1; end
            OP_ADDI: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
            OP_BEQ:  dec.branch = 1'b1;
            OP_JAL:  begin dec.reg_write = 1'b1; dec.reg_dst = 2'b10; end
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

    // Load-use hazard: the load in EX targets a register this instruction reads.
    assign stall = ex_q.mem_read && (ex_q.rt != '0) &&
                   ((ex_q.rt == rs) || (ex_q.rt == rt)) && !halted_q;

    always_comb begin
        ex_d     = ex_q;
        halted_d = halted_q;
        if (bus.enable_i) begin
            if (bus.flush_i || stall || halted_q) begin
                ex_d = '0;
            end else begin
                ex_d     = dec;
                halted_d = is_halt;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            ex_q     <= '0;
            halted_q <= 1'b0;
            for (int i = 0; i < 2**NB_REG; i++) regs_q[i] <= '0;
        end else begin
            ex_q     <= ex_d;
            halted_q <= halted_d;
            regs_q   <= regs_d;
        end
    end

    assign bus.dbg_data_o      = dbg;
    assign bus.stall_o         = stall;
    assign bus.halted_o        = halted_q;
    assign bus.ex_opcode_o     = ex_q.opcode;
    assign bus.ex_funct_o      = ex_q.funct;
    assign bus.ex_rs_o         = ex_q.rs;
    assign bus.ex_rt_o         = ex_q.rt;
    assign bus.ex_rd_o         = ex_q.rd;
    assign bus.ex_shamt_o      = ex_q.shamt;
    assign bus.ex_data_ra_o    = ex_q.data_ra;
    assign bus.ex_data_rb_o    = ex_q.data_rb;
    assign bus.ex_imm_o        = ex_q.imm;
    assign bus.ex_reg_dst_o    = ex_q.reg_dst;
    assign bus.ex_alu_src_o    = ex_q.alu_src;
    assign bus.ex_mem_read_o   = ex_q.mem_read;
    assign bus.ex_mem_write_o  = ex_q.mem_write;
    assign bus.ex_mem_to_reg_o = ex_q.mem_to_reg;
    assign bus.ex_reg_write_o  = ex_q.reg_write;
    assign bus.ex_branch_o     = ex_q.branch;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, decode, load-use stall, flush/hold, HALT, bank writes.
module tb_decode_stage;
    localparam logic [31:0] I_ADDI = 32'h2002FFFD;  // addi r2,r0,-3
    localparam logic [31:0] I_LW   = 32'h8C230000;  // lw r3,0(r1)
    localparam logic [31:0] I_ADD  = 32'h00632020;  // add r4,r3,r3
    localparam logic [31:0] I_ADD7 = 32'h00E02820;  // add r5,r7,r0
    localparam logic [31:0] I_HALT = 32'hFC000000;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    decode_stage_if #(.NB_DATA(32), .NB_REG(5), .NB_OPCODE(6)) bus ();

    decode_stage #(.NB_DATA(32), .NB_REG(5), .NB_OPCODE(6)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
        bus.reg_write_i      = en;
        bus.write_register_i = addr;
        bus.data_rw_i        = data;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.enable_i = 1'b1;
        bus.flush_i = 1'b0;
        bus.instruction_i = '0;
        bus.dbg_addr_i = '0;
        wb(1'b0, 5'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ex_reg_write", bus.ex_reg_write_o, 1'b0);
        check("rst_stall", bus.stall_o, 1'b0);
        check("rst_halted", bus.halted_o, 1'b0);

        // Asynchronous reset pulse mid-cycle
        wb(1'b1, 5'd5, 32'h1234);
        bus.instruction_i = I_ADDI;
        bus.dbg_addr_i = 5'd5;
        tick();
        wb(1'b0, 5'd0, 32'h0);
        #1;
        check("pre_rst_dbg_r5", bus.dbg_data_o, 32'h1234);
        check("pre_rst_alu_src", bus.ex_alu_src_o, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_imm", bus.ex_imm_o, 32'h0);
        check("async_rst_alu_src", bus.ex_alu_src_o, 1'b0);
        check("async_rst_dbg_r5", bus.dbg_data_o, 32'h0);
        rst = 1'b0;

        // ADDI decode, also writes r7=0x11 for the later bypass test
        bus.instruction_i = I_ADDI;
        wb(1'b1, 5'd7, 32'h11);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        check("addi_imm", bus.ex_imm_o, 32'hFFFFFFFD);
        check("addi_alu_src", bus.ex_alu_src_o, 1'b1);
        check("addi_reg_write", bus.ex_reg_write_o, 1'b1);
        check("addi_reg_dst", bus.ex_reg_dst_o, 2'b00);
        check("addi_rt", bus.ex_rt_o, 5'd2);
        check("addi_mem_read", bus.ex_mem_read_o, 1'b0);

        // Load-use: LW r3 then ADD r4,r3,r3
        bus.instruction_i = I_LW;
        wb(1'b1, 5'd3, 32'h55);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        check("lw_mem_read", bus.ex_mem_read_o, 1'b1);
        check("lw_mem_to_reg", bus.ex_mem_to_reg_o, 1'b1);
        check("lw_rt", bus.ex_rt_o, 5'd3);
        bus.instruction_i = I_ADD;
        #1;
        check("lu_stall", bus.stall_o, 1'b1);
        tick();
        check("lu_bubble_reg_write", bus.ex_reg_write_o, 1'b0);
        check("lu_bubble_mem_read", bus.ex_mem_read_o, 1'b0);
        check("lu_bubble_opcode", bus.ex_opcode_o, 6'h0);
        check("lu_stall_cleared", bus.stall_o, 1'b0);
        tick();
        check("add_rd", bus.ex_rd_o, 5'd4);
        check("add_reg_dst", bus.ex_reg_dst_o, 2'b01);
        check("add_reg_write", bus.ex_reg_write_o, 1'b1);
        check("add_funct", bus.ex_funct_o, 6'h20);
        check("add_data_ra", bus.ex_data_ra_o, 32'h55);
        check("add_data_rb", bus.ex_data_rb_o, 32'h55);

        // r0 is never written
        bus.instruction_i = '0;
        wb(1'b1, 5'd0, 32'hFFFF);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        bus.dbg_addr_i = 5'd0;
        #1;
        check("r0_reads_zero", bus.dbg_data_o, 32'h0);

        // Same-cycle write of r7 with rs=7
        bus.instruction_i = I_ADD7;
        wb(1'b1, 5'd7, 32'hAA);
        bus.dbg_addr_i = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("wb_same_cycle_dbg", bus.dbg_data_o, 32'hAA);
`else
        check("wb_same_cycle_dbg", bus.dbg_data_o, 32'h11);
`endif
        tick();
        wb(1'b0, 5'd0, 32'h0);
`ifdef REGFILE_BYPASS_EN
        check("wb_same_cycle_ra", bus.ex_data_ra_o, 32'hAA);
`else
        check("wb_same_cycle_ra", bus.ex_data_ra_o, 32'h11);
`endif
        #1;
        check("r7_after_write", bus.dbg_data_o, 32'hAA);

        // Flush while stalled
        bus.instruction_i = I_LW;
        tick();
        bus.instruction_i = I_ADD;
        bus.flush_i = 1'b1;
        #1;
        check("flush_stall_high", bus.stall_o, 1'b1);
        tick();
        bus.flush_i = 1'b0;
        check("flush_bubble_reg_write", bus.ex_reg_write_o, 1'b0);
        check("flush_bubble_mem_read", bus.ex_mem_read_o, 1'b0);

        // Hold with enable low while stalled
        bus.instruction_i = I_LW;
        tick();
        bus.instruction_i = I_ADD;
        bus.enable_i = 1'b0;
        repeat (3) tick();
        check("hold_mem_read", bus.ex_mem_read_o, 1'b1);
        check("hold_rt", bus.ex_rt_o, 5'd3);
        check("hold_stall", bus.stall_o, 1'b1);
        bus.enable_i = 1'b1;
        tick();
        check("hold_release_bubble", bus.ex_reg_write_o, 1'b0);
        tick();
        check("hold_release_add", bus.ex_rd_o, 5'd4);

        // HALT is sticky; bank writes still land
        bus.instruction_i = I_HALT;
        tick();
        check("halt_halted", bus.halted_o, 1'b1);
        check("halt_opcode", bus.ex_opcode_o, 6'h3F);
        check("halt_reg_write", bus.ex_reg_write_o, 1'b0);
        bus.instruction_i = I_ADDI;
        wb(1'b1, 5'd9, 32'h99);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        check("post_halt_imm", bus.ex_imm_o, 32'h0);
        check("post_halt_alu_src", bus.ex_alu_src_o, 1'b0);
        check("post_halt_halted", bus.halted_o, 1'b1);
        bus.dbg_addr_i = 5'd9;
        #1;
        check("post_halt_r9", bus.dbg_data_o, 32'h99);

        // Reset after HALT, then normal load
        rst = 1'b1;
        #1;
        check("rst_halt_cleared", bus.halted_o, 1'b0);
        check("rst_halt_r9", bus.dbg_data_o, 32'h0);
        rst = 1'b0;
        tick();
        check("after_rst_alu_src", bus.ex_alu_src_o, 1'b1);
        check("after_rst_imm", bus.ex_imm_o, 32'hFFFFFFFD);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
